// File: rtl/trash_pkg.sv
// Shared types and constants for the trash CPU instruction sequencer.
// Provides the opcode and FSM state enums, the instruction word layout,
// the register-file write-source selects and helpers that slice and
// validate instruction fields.
package trash_pkg;

    localparam int unsigned PROG_DEPTH  = 8;
    localparam int unsigned PC_W        = 3;
    localparam int unsigned ALU_TIMEOUT = 15;
    localparam int unsigned TO_W        = 4;
    localparam int unsigned INSTR_W     = 16;

    // Register-file write data source
    localparam logic [1:0] WSEL_IMM = 2'd0;
    localparam logic [1:0] WSEL_ALU = 2'd1;
    localparam logic [1:0] WSEL_MEM = 2'd2;

    typedef enum logic [3:0] {
        OP_NOOP     = 4'd0,
        OP_STORE    = 4'd1,
        OP_CALC     = 4'd2,
        OP_MEMSTORE = 4'd3,
        OP_MEMLOAD  = 4'd4,
        OP_JUMP     = 4'd5,
        OP_JUMPIF   = 4'd6,
        OP_OUT      = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_ALU,
        S_WAIT_MEM,
        S_HALT
    } state_e;

    // Instruction word: opcode, field F, field B
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] f;
        logic [7:0] b;
    } instr_t;

    // Upper register nibble of field B (rin / compare A / load target)
    function automatic logic [3:0] fld_hi(input instr_t i);
        return i.b[7:4];
    endfunction

    // Lower register nibble of field B (rout / compare B)
    function automatic logic [3:0] fld_lo(input instr_t i);
        return i.b[3:0];
    endfunction

    // Only registers 0-3 exist; any upper bit set is a fault
    function automatic logic reg_ok(input logic [3:0] r);
        return r[3:2] == 2'b00;
    endfunction

    function automatic logic [1:0] reg_sel(input logic [3:0] r);
        return r[1:0];
    endfunction

endpackage

// File: rtl/trash_exec_ctrl_if.sv
// Control bus between the sequencer and the external datapath
// (register file, data memory, ALU, output latch).
// master: sequencer side, drives strobes/addresses, receives
//         mem_rvalid, alu_ack and cmp_eq.
// slave:  datapath side.
interface trash_exec_ctrl_if;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [1:0] rf_wsel;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic [7:0] imm;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] mem_addr;
    logic       mem_rvalid;
    logic       alu_req;
    logic [3:0] alu_op;
    logic       alu_ack;
    logic       cmp_eq;
    logic       out_we;

    modport master (
        output rf_we, rf_waddr, rf_wsel, rf_raddr_a, rf_raddr_b, imm,
        output mem_we, mem_re, mem_addr, alu_req, alu_op, out_we,
        input  mem_rvalid, alu_ack, cmp_eq
    );

    modport slave (
        input  rf_we, rf_waddr, rf_wsel, rf_raddr_a, rf_raddr_b, imm,
        input  mem_we, mem_re, mem_addr, alu_req, alu_op, out_we,
        output mem_rvalid, alu_ack, cmp_eq
    );

endinterface

// File: rtl/trash_prog_mem.sv
// Program store: PROG_DEPTH x 16-bit words with an auto-incrementing
// write pointer and an asynchronous read port. Contents are not reset.
// Ports: clk, reset (sync, active-high), we/wdata (write at pointer),
//        raddr/rdata (async read).
module trash_prog_mem
    import trash_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];
    logic [PC_W-1:0]    wptr;

    // Write pointer wraps naturally at PROG_DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
        end else if (we) begin
            wptr <= wptr + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trash_exec_ctrl.sv
// Instruction sequencer for the trash CPU: program store, PC, decode and
// a multi-cycle FSM that issues single-cycle strobes to the datapath.
// Ports: clk, reset (sync, active-high); prog_en/prog_we/prog_wdata load
//        the program while idle; run starts/continues execution;
//        dp carries datapath strobes and responses; pc, busy, fault report
//        status (fault is sticky until reset).
module trash_exec_ctrl
    import trash_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_en,
    input  logic               prog_we,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               run,
    trash_exec_ctrl_if.master  dp,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               fault
);

    state_e             state, state_n;
    instr_t             ir, ir_n;
    logic [PC_W-1:0]    pc_n, pc_inc;
    logic [TO_W-1:0]    cnt, cnt_n;
    logic               fault_n;
    logic               prog_wr;
    logic [INSTR_W-1:0] prog_rdata;
    logic               legal;
    state_e             seq_next;

    logic       rf_we, mem_we, mem_re, alu_req, out_we;
    logic [1:0] rf_waddr, rf_wsel, raddr_a, raddr_b;

    // Programming is only accepted while idle
    assign prog_wr = (state == S_IDLE) && prog_en && prog_we;

    trash_prog_mem u_prog (
        .clk   (clk),
        .reset (reset),
        .we    (prog_wr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (prog_rdata)
    );

    // Decode legality of the instruction register
    always_comb begin
        legal = 1'b1;
        case (ir.op)
            OP_NOOP, OP_MEMSTORE, OP_JUMP: legal = 1'b1;
            OP_STORE, OP_OUT:              legal = reg_ok(ir.f);
            OP_CALC, OP_JUMPIF:            legal = reg_ok(fld_hi(ir)) && reg_ok(fld_lo(ir));
            OP_MEMLOAD:                    legal = reg_ok(fld_hi(ir));
            default:                       legal = 1'b0;
        endcase
    end

    assign pc_inc   = pc + PC_W'(1);
    assign seq_next = run ? S_FETCH : S_IDLE;

    // Next-state and strobe decode
    always_comb begin
        state_n  = state;
        ir_n     = ir;
        pc_n     = pc;
        cnt_n    = cnt;
        fault_n  = fault;
        rf_we    = 1'b0;
        rf_waddr = 2'd0;
        rf_wsel  = WSEL_IMM;
        raddr_a  = 2'd0;
        raddr_b  = 2'd0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        alu_req  = 1'b0;
        out_we   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!prog_en && run) begin
                    pc_n    = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_n    = instr_t'(prog_rdata);
                state_n = S_EXEC;
            end
            S_EXEC: begin
                if (!legal) begin
                    fault_n = 1'b1;
                    state_n = S_HALT;
                end else begin
                    state_n = seq_next;
                    pc_n    = pc_inc;
                    case (ir.op)
                        OP_STORE: begin
                            rf_we    = 1'b1;
                            rf_wsel  = WSEL_IMM;
                            rf_waddr = reg_sel(ir.f);
                        end
                        OP_MEMSTORE: mem_we = 1'b1;
                        OP_OUT: begin
                            raddr_a = reg_sel(ir.f);
                            out_we  = 1'b1;
                        end
                        OP_JUMP: pc_n = ir.f[PC_W-1:0];
                        OP_JUMPIF: begin
                            raddr_a = reg_sel(fld_hi(ir));
                            raddr_b = reg_sel(fld_lo(ir));
                            if (dp.cmp_eq) begin
                                pc_n = ir.f[PC_W-1:0];
                            end
                        end
                        OP_CALC: begin
                            raddr_a = reg_sel(fld_hi(ir));
                            pc_n    = pc;
                            cnt_n   = '0;
                            state_n = S_WAIT_ALU;
                        end
                        OP_MEMLOAD: begin
                            mem_re  = 1'b1;
                            pc_n    = pc;
                            state_n = S_WAIT_MEM;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT_ALU: begin
                alu_req = 1'b1;
                raddr_a = reg_sel(fld_hi(ir));
                if (dp.alu_ack) begin
                    rf_we    = 1'b1;
                    rf_wsel  = WSEL_ALU;
                    rf_waddr = reg_sel(fld_lo(ir));
                    pc_n     = pc_inc;
                    state_n  = seq_next;
                end else if (cnt == TO_W'(ALU_TIMEOUT - 1)) begin
                    // Last permitted cycle passed without an ack
                    fault_n  = 1'b1;
                    state_n  = S_HALT;
                end else begin
                    cnt_n    = cnt + TO_W'(1);
                end
            end
            S_WAIT_MEM: begin
                if (dp.mem_rvalid) begin
                    rf_we    = 1'b1;
                    rf_wsel  = WSEL_MEM;
                    rf_waddr = reg_sel(fld_hi(ir));
                    pc_n     = pc_inc;
                    state_n  = seq_next;
                end else begin
                    fault_n  = 1'b1;
                    state_n  = S_HALT;
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ir    <= '0;
            pc    <= '0;
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
            fault <= fault_n;
        end
    end

    assign busy = (state != S_IDLE) && (state != S_HALT);

    assign dp.rf_we      = rf_we;
    assign dp.rf_waddr   = rf_waddr;
    assign dp.rf_wsel    = rf_wsel;
    assign dp.rf_raddr_a = raddr_a;
    assign dp.rf_raddr_b = raddr_b;
    assign dp.imm        = ir.b;
    assign dp.mem_we     = mem_we;
    assign dp.mem_re     = mem_re;
    assign dp.mem_addr   = ir.f;
    assign dp.alu_req    = alu_req;
    assign dp.alu_op     = ir.f;
    assign dp.out_we     = out_we;

endmodule

// File: tb/tb_trash_exec_ctrl.sv
// Self-checking bench for trash_exec_ctrl: single-instruction vector table
// plus directed multi-cycle sequences (run flow, ALU handshake/timeout,
// memory load, program-store wrap, busy programming, reset abort).
module tb_trash_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_en;
    logic        prog_we;
    logic [15:0] prog_wdata;
    logic        run;
    logic [2:0]  pc;
    logic        busy;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    trash_exec_ctrl_if dp ();

    trash_exec_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .prog_en    (prog_en),
        .prog_we    (prog_we),
        .prog_wdata (prog_wdata),
        .run        (run),
        .dp         (dp),
        .pc         (pc),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        cmp;
        logic        rf_we;
        logic [1:0]  waddr;
        logic        mem_we;
        logic [3:0]  maddr;
        logic        out_we;
        logic        chk_ra;
        logic [1:0]  ra;
        logic        chk_rb;
        logic [1:0]  rb;
        logic [7:0]  imm;
        logic [2:0]  pc;
        logic        fault;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        prog_en       = 1'b0;
        prog_we       = 1'b0;
        prog_wdata    = '0;
        run           = 1'b0;
        dp.cmp_eq     = 1'b0;
        dp.alu_ack    = 1'b0;
        dp.mem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] w);
        prog_en    = 1'b1;
        prog_we    = 1'b1;
        prog_wdata = w;
        tick();
        prog_en    = 1'b0;
        prog_we    = 1'b0;
    endtask

    function automatic logic [4:0] strobes();
        return {dp.rf_we, dp.mem_we, dp.mem_re, dp.out_we, dp.alu_req};
    endfunction

    initial begin
        int req_cycles;
        int reqn;
        int we_cnt;
        int rf_cyc;
        int out_cyc;
        logic [1:0] s_waddr, s_wsel, s_ra;
        logic [7:0] s_imm;

        //          instr    cmp rfwe wa memwe ma  out cra ra crb rb  imm    pc   flt
        vecs[0]  = '{16'h0000, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 3'd1, 0};
        vecs[1]  = '{16'h115A, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 0, 8'h5A, 3'd1, 0};
        vecs[2]  = '{16'h13FF, 0, 1, 3, 0, 4'h0, 0, 0, 0, 0, 0, 8'hFF, 3'd1, 0};
        vecs[3]  = '{16'h3C33, 0, 0, 0, 1, 4'hC, 0, 0, 0, 0, 0, 8'h33, 3'd1, 0};
        vecs[4]  = '{16'h7200, 0, 0, 0, 0, 4'h0, 1, 1, 2, 0, 0, 8'h00, 3'd1, 0};
        vecs[5]  = '{16'h5F00, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 3'd7, 0};
        vecs[6]  = '{16'h5300, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 3'd3, 0};
        vecs[7]  = '{16'h6512, 1, 0, 0, 0, 4'h0, 0, 1, 1, 1, 2, 8'h12, 3'd5, 0};
        vecs[8]  = '{16'h6512, 0, 0, 0, 0, 4'h0, 0, 1, 1, 1, 2, 8'h12, 3'd1, 0};
        vecs[9]  = '{16'h9000, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 3'd0, 1};
        vecs[10] = '{16'h1401, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h01, 3'd0, 1};
        vecs[11] = '{16'h7800, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 3'd0, 1};
        vecs[12] = '{16'h6540, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h40, 3'd0, 1};
        vecs[13] = '{16'hF123, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h23, 3'd0, 1};

        // Reset state
        do_reset();
        chk("reset pc", 32'(pc), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        chk("reset strobes", 32'(strobes()), 32'd0);

        // Single instruction at entry 0, run pulsed for one cycle
        for (int i = 0; i < NV; i++) begin
            do_reset();
            write_word(vecs[i].instr);
            run       = 1'b1;
            dp.cmp_eq = vecs[i].cmp;
            tick();
            run = 1'b0;
            tick();
            @(negedge clk);
            chk($sformatf("v%0d strobes", i), 32'(strobes()),
                32'({vecs[i].rf_we, vecs[i].mem_we, 1'b0, vecs[i].out_we, 1'b0}));
            if (vecs[i].rf_we) begin
                chk($sformatf("v%0d waddr", i), 32'(dp.rf_waddr), 32'(vecs[i].waddr));
                chk($sformatf("v%0d wsel", i), 32'(dp.rf_wsel), 32'd0);
            end
            if (vecs[i].rf_we || vecs[i].mem_we)
                chk($sformatf("v%0d imm", i), 32'(dp.imm), 32'(vecs[i].imm));
            if (vecs[i].mem_we)
                chk($sformatf("v%0d mem_addr", i), 32'(dp.mem_addr), 32'(vecs[i].maddr));
            if (vecs[i].chk_ra)
                chk($sformatf("v%0d raddr_a", i), 32'(dp.rf_raddr_a), 32'(vecs[i].ra));
            if (vecs[i].chk_rb)
                chk($sformatf("v%0d raddr_b", i), 32'(dp.rf_raddr_b), 32'(vecs[i].rb));
            tick();
            chk($sformatf("v%0d pc", i), 32'(pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d fault", i), 32'(fault), 32'(vecs[i].fault));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'd0);
        end

        // STORE r1,0x5A; OUT r1 with run held
        do_reset();
        write_word(16'h115A);
        write_word(16'h7100);
        rf_cyc = -1; out_cyc = -1; s_waddr = '0; s_imm = '0; s_ra = '0;
        run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) run = 1'b0;
            @(negedge clk);
            if (dp.rf_we && rf_cyc < 0) begin
                rf_cyc = c; s_waddr = dp.rf_waddr; s_imm = dp.imm;
            end
            if (dp.out_we && out_cyc < 0) begin
                out_cyc = c; s_ra = dp.rf_raddr_a;
            end
            tick();
        end
        chk("seq rf_we cycle", 32'(rf_cyc), 32'd2);
        chk("seq rf_waddr", 32'(s_waddr), 32'd1);
        chk("seq imm", 32'(s_imm), 32'h5A);
        chk("seq out_we cycle", 32'(out_cyc), 32'd4);
        chk("seq out raddr_a", 32'(s_ra), 32'd1);
        chk("seq pc", 32'(pc), 32'd2);
        chk("seq busy", 32'(busy), 32'd0);

        // CALC op=5 rin=1 rout=2, ack in the 3rd request cycle, run dropped mid-wait
        do_reset();
        write_word(16'h2512);
        req_cycles = 0; reqn = 0; we_cnt = 0; s_wsel = '0; s_waddr = '0; s_ra = '0;
        run = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) run = 1'b0;
            if (dp.alu_req) reqn++;
            dp.alu_ack = dp.alu_req && (reqn == 3);
            @(negedge clk);
            if (dp.alu_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    chk("calc alu_op", 32'(dp.alu_op), 32'd5);
                    s_ra = dp.rf_raddr_a;
                end
            end
            if (dp.rf_we) begin
                we_cnt++; s_wsel = dp.rf_wsel; s_waddr = dp.rf_waddr;
                chk("calc ack with rf_we", 32'(dp.alu_ack), 32'd1);
            end
            tick();
        end
        dp.alu_ack = 1'b0;
        chk("calc req cycles", 32'(req_cycles), 32'd3);
        chk("calc raddr_a", 32'(s_ra), 32'd1);
        chk("calc rf_we count", 32'(we_cnt), 32'd1);
        chk("calc wsel", 32'(s_wsel), 32'd1);
        chk("calc waddr", 32'(s_waddr), 32'd2);
        chk("calc pc", 32'(pc), 32'd1);
        chk("calc idle", 32'(busy), 32'd0);
        chk("calc fault", 32'(fault), 32'd0);

        // CALC never acked: timeout after 15 request cycles, HALT holds with run high
        do_reset();
        write_word(16'h2512);
        req_cycles = 0;
        run = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dp.alu_req) req_cycles++;
            tick();
        end
        chk("timeout req cycles", 32'(req_cycles), 32'd15);
        chk("timeout fault", 32'(fault), 32'd1);
        chk("halt busy", 32'(busy), 32'd0);
        chk("halt pc", 32'(pc), 32'd0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        chk("halt->idle restart busy", 32'(busy), 32'd1);
        chk("fault sticky", 32'(fault), 32'd1);
        run = 1'b0;
        do_reset();
        chk("reset clears fault", 32'(fault), 32'd0);

        // MEMLOAD F=3 into r2, rvalid next cycle
        write_word(16'h4320);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        @(negedge clk);
        chk("memload mem_re", 32'(dp.mem_re), 32'd1);
        chk("memload mem_addr", 32'(dp.mem_addr), 32'd3);
        tick();
        dp.mem_rvalid = 1'b1;
        @(negedge clk);
        chk("memload rf_we", 32'(dp.rf_we), 32'd1);
        chk("memload wsel", 32'(dp.rf_wsel), 32'd2);
        chk("memload waddr", 32'(dp.rf_waddr), 32'd2);
        tick();
        dp.mem_rvalid = 1'b0;
        chk("memload pc", 32'(pc), 32'd1);
        chk("memload fault", 32'(fault), 32'd0);

        // MEMLOAD without rvalid -> fault
        do_reset();
        write_word(16'h4320);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("memload miss rf_we", 32'(dp.rf_we), 32'd0);
        tick();
        chk("memload miss fault", 32'(fault), 32'd1);
        chk("memload miss pc", 32'(pc), 32'd0);

        // prog_en beats run; 9 writes wrap; writes while busy ignored
        do_reset();
        prog_en = 1'b1;
        run     = 1'b1;
        tick();
        chk("prog_en wins busy", 32'(busy), 32'd0);
        run = 1'b0;
        write_word(16'h5700);
        for (int k = 1; k < 8; k++) write_word(16'h0000);
        write_word(16'h0000);
        run = 1'b1;
        tick();
        run        = 1'b0;
        prog_en    = 1'b1;
        prog_we    = 1'b1;
        prog_wdata = 16'h5400;
        tick();
        tick();
        prog_en = 1'b0;
        prog_we = 1'b0;
        chk("wrap first run pc", 32'(pc), 32'd1);
        write_word(16'h5200);
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        chk("wrap/busy-prog pc", 32'(pc), 32'd2);
        chk("wrap fault", 32'(fault), 32'd0);

        // Reset during ALU wait drops alu_req on the next edge
        do_reset();
        write_word(16'h2512);
        run = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        chk("abort alu_req before", 32'(dp.alu_req), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort alu_req", 32'(dp.alu_req), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        reset = 1'b0;
        run   = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
